led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_pkg.sv | 17 +
 rtl/led_tick_gen.sv | 35 +++
 rtl/led_pattern_gen.sv | 151 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern generator: requested/active mode and
// the bounce direction used by the SCAN and BREATHE patterns.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled clkin cycles.
module led_tick_gen #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clkin,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;

  always_comb begin
    presc_d = presc_q;
    if (enable) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Combinational so the pulse drops the instant enable or reset does.
  assign tick = enable && (presc_q == PRESC_LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: COUNT, SCAN, BREATHE (PWM) and HOLD patterns stepped
// by a prescaled tick, with a registered, optionally inverted LED drive.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS   = 12,
  parameter int TICK_DIV   = 5000000,
  parameter int PWM_WIDTH  = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [NUM_LEDS-1:0] pattern_in,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick
);

  localparam int POS_W = $clog2(NUM_LEDS);
  localparam logic [POS_W-1:0]     POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_WIDTH-1:0] DUTY_MAX = '1;
  localparam logic [NUM_LEDS-1:0]  LEDS_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  mode_e                active_mode_q, active_mode_d;
  mode_e                req_mode;
  logic [NUM_LEDS-1:0]  count_q, count_d;
  logic [NUM_LEDS-1:0]  hold_q, hold_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  dir_e                 dir_q, dir_d;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  dir_e                 duty_dir_q, duty_dir_d;
  logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0]  pattern;
  logic [NUM_LEDS-1:0]  leds_q, leds_d;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clkin (clkin),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  always_comb begin
    active_mode_d = active_mode_q;
    count_d       = count_q;
    hold_d        = hold_q;
    pos_d         = pos_q;
    dir_d         = dir_q;
    duty_d        = duty_q;
    duty_dir_d    = duty_dir_q;
    pwm_cnt_d     = pwm_cnt_q;
    req_mode      = mode_e'(mode);

    if (enable) begin
      pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);
    end

    if (tick) begin
      // A mode change reloads the new pattern instead of advancing it.
      if (req_mode != active_mode_q) begin
        active_mode_d = req_mode;
        case (req_mode)
          MODE_COUNT:   count_d = '0;
          MODE_SCAN:    begin pos_d = '0; dir_d = DIR_UP; end
          MODE_BREATHE: begin duty_d = '0; duty_dir_d = DIR_UP; end
          default:      hold_d = pattern_in;
        endcase
      end else begin
        case (active_mode_q)
          MODE_COUNT: count_d = count_q + NUM_LEDS'(1);
          MODE_SCAN: begin
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_LAST) begin
                dir_d = DIR_DOWN;
                pos_d = POS_LAST - POS_W'(1);
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = POS_W'(1);
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
          MODE_BREATHE: begin
            if (duty_dir_q == DIR_UP) begin
              if (duty_q == DUTY_MAX) begin
                duty_dir_d = DIR_DOWN;
                duty_d     = DUTY_MAX - PWM_WIDTH'(1);
              end else begin
                duty_d = duty_q + PWM_WIDTH'(1);
              end
            end else if (duty_q == '0) begin
              duty_dir_d = DIR_UP;
              duty_d     = PWM_WIDTH'(1);
            end else begin
              duty_d = duty_q - PWM_WIDTH'(1);
            end
          end
          default: hold_d = pattern_in;
        endcase
      end
    end
  end

  always_comb begin
    pattern = '0;
    case (active_mode_q)
      MODE_COUNT: pattern = count_q;
      MODE_SCAN: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          pattern[i] = (pos_q == POS_W'(i));
        end
      end
      MODE_BREATHE: pattern = {NUM_LEDS{pwm_cnt_q < duty_q}};
      default:      pattern = hold_q;
    endcase
    leds_d = (ACTIVE_LOW != 0) ? ~pattern : pattern;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      active_mode_q <= MODE_COUNT;
      count_q       <= '0;
      hold_q        <= '0;
      pos_q         <= '0;
      dir_q         <= DIR_UP;
      duty_q        <= '0;
      duty_dir_q    <= DIR_UP;
      pwm_cnt_q     <= '0;
      leds_q        <= LEDS_OFF;
    end else begin
      active_mode_q <= active_mode_d;
      count_q       <= count_d;
      hold_q        <= hold_d;
      pos_q         <= pos_d;
      dir_q         <= dir_d;
      duty_q        <= duty_d;
      duty_dir_q    <= duty_dir_d;
      pwm_cnt_q     <= pwm_cnt_d;
      leds_q        <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a cycle-level reference model derived
// from the pattern rules feeds a queue that an independent monitor drains.
module tb_led_pattern_gen;

  localparam int NL = 4;
  localparam int TD = 4;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    mode;
  logic [NL-1:0] pattern_in;
  logic [NL-1:0] leds0, leds1;
  logic          tick0, tick1;

  led_pattern_gen #(.NUM_LEDS(NL), .TICK_DIV(TD), .PWM_WIDTH(PW), .ACTIVE_LOW(0)) u_dut (
    .clkin(clk), .reset(reset), .enable(enable), .mode(mode),
    .pattern_in(pattern_in), .leds(leds0), .tick(tick0));

  led_pattern_gen #(.NUM_LEDS(NL), .TICK_DIV(TD), .PWM_WIDTH(PW), .ACTIVE_LOW(1)) u_dut_al (
    .clkin(clk), .reset(reset), .enable(enable), .mode(mode),
    .pattern_in(pattern_in), .leds(leds1), .tick(tick1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic          tick;
    logic [NL-1:0] leds;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: counters of enabled cycles and tick steps.
  int            m_presc, m_pwm, m_k, m_active;
  logic [NL-1:0] m_hold, m_leds;

  function automatic int bounce(input int k, input int n);
    int per = 2 * (n - 1);
    int p   = k % per;
    return (p < n) ? p : per - p;
  endfunction

  function automatic logic [NL-1:0] m_pattern();
    case (m_active)
      0:       return NL'(m_k % (1 << NL));
      1:       return NL'(1 << bounce(m_k, NL));
      2:       return (m_pwm < bounce(m_k, 1 << PW)) ? '1 : '0;
      default: return m_hold;
    endcase
  endfunction

  task automatic model_reset();
    m_presc = 0; m_pwm = 0; m_k = 0; m_active = 0;
    m_hold = '0; m_leds = '0;
  endtask

  task automatic model_step();
    sb_item_t it;
    if (reset) begin
      model_reset();
      it.tick = 1'b0;
      it.leds = '0;
      sb_q.push_back(it);
      return;
    end
    it.tick = enable && (m_presc == TD - 1);
    it.leds = m_leds;
    sb_q.push_back(it);
    m_leds = m_pattern();
    if (enable) begin
      if (it.tick) begin
        if (int'(mode) != m_active) begin
          m_active = int'(mode);
          m_k = 0;
          if (mode == 2'd3) m_hold = pattern_in;
        end else begin
          m_k++;
          if (m_active == 3) m_hold = pattern_in;
        end
      end
      m_presc = (m_presc + 1) % TD;
      m_pwm   = (m_pwm + 1) % (1 << PW);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] md,
                       input logic [NL-1:0] pin);
    @(negedge clk);
    reset = r; enable = e; mode = md; pattern_in = pin;
    model_step();
  endtask

  // Monitor: every sample point pops the expected response for that cycle.
  initial begin
    sb_item_t      e;
    logic [NL-1:0] inv;
    forever begin
      @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        inv = ~e.leds;
        chk("tick", {31'b0, tick0}, {31'b0, e.tick});
        chk("tick_al", {31'b0, tick1}, {31'b0, e.tick});
        chk("leds", {28'b0, leds0}, {28'b0, e.leds});
        chk("leds_al", {28'b0, leds1}, {28'b0, inv});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; mode = 2'd0; pattern_in = '0;
    model_reset();
    #1;
    chk("reset_leds", {28'b0, leds0}, 32'h0);
    chk("reset_leds_al", {28'b0, leds1}, 32'hF);
    chk("reset_tick", {31'b0, tick0}, 32'h0);
    repeat (3) drive(1'b1, 1'b1, 2'd0, '0);

    // COUNT through a full wrap of the 4-bit counter.
    repeat (TD * 18) drive(1'b0, 1'b1, 2'd0, '0);

    // SCAN from reset, then a 10-cycle enable drop mid-scan.
    repeat (2) drive(1'b1, 1'b1, 2'd1, '0);
    repeat (TD * 5 + 2) drive(1'b0, 1'b1, 2'd1, '0);
    repeat (10) drive(1'b0, 1'b0, 2'd1, '0);
    repeat (TD * 6) drive(1'b0, 1'b1, 2'd1, '0);

    // BREATHE up and down, then asynchronous reset between edges.
    repeat (TD * 20 + 1) drive(1'b0, 1'b1, 2'd2, '0);
    drive(1'b0, 1'b1, 2'd2, '0);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_leds", {28'b0, leds0}, 32'h0);
    chk("async_leds_al", {28'b0, leds1}, 32'hF);
    chk("async_tick", {31'b0, tick0}, 32'h0);
    repeat (2) drive(1'b1, 1'b1, 2'd2, '0);

    // HOLD entered mid-prescale with a fixed pattern.
    repeat (TD + 1) drive(1'b0, 1'b1, 2'd0, '0);
    repeat (TD * 3) drive(1'b0, 1'b1, 2'd3, 4'b1010);

    // Randomized modes, enables and hold patterns.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] md;
      md = mode;
      if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
      drive(1'b0, $urandom_range(0, 7) != 0, md, NL'($urandom));
    end

    repeat (2) @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
